// File: rtl/frame_pkg.sv
// frame_pkg
// Shared constants and types for the frame read/write stream blocks:
// frame geometry, FSM state encoding, column-set mode codes and burst lengths.
// A helper maps a mode to its burst length.
package frame_pkg;

  localparam int DATA_W      = 32;
  localparam int N_ROWS      = 4;
  localparam int N_COLS      = 4;
  localparam int FRAME_WORDS = N_ROWS * N_COLS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SMALL = 1'b0;
  localparam logic MODE_BIG   = 1'b1;

  localparam logic [3:0] LEN_SMALL = 4'd4;
  localparam logic [3:0] LEN_BIG   = 4'd12;

  function automatic logic [3:0] burst_len(input logic mode);
    return (mode == MODE_BIG) ? LEN_BIG : LEN_SMALL;
  endfunction

endpackage

// File: rtl/frame_index_gen.sv
// frame_index_gen
// Combinational map from (mode, word counter) to frame index and last flag.
// Words are walked column-major inside the selected column set:
//   mode SMALL: column 0 only       -> k = 0,4,8,12
//   mode BIG  : columns 1..3        -> k = 1,5,9,13, 2,6,10,14, 3,7,11,15
// Ports:
//   mode - column-set select (MODE_SMALL / MODE_BIG)
//   cnt  - word position within the burst
//   k    - frame index, k = row*4 + col
//   last - cnt is the final position of the burst
module frame_index_gen
  import frame_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] cnt,
  output logic [3:0] k,
  output logic       last
);

  logic [1:0] col;

  always_comb begin
    // row = cnt mod 4; column advances every 4 words in BIG mode
    col  = (mode == MODE_BIG) ? (2'd1 + cnt[3:2]) : 2'd0;
    k    = {cnt[1:0], col};
    last = (cnt == (burst_len(mode) - 4'd1));
  end

endmodule

// File: rtl/frame_stream_reader.sv
// frame_stream_reader
// Snapshots a 4x4 frame of words on start and streams the selected column set
// one word per cycle on a valid/ready interface.
//
//   state | meaning
//   IDLE  | waiting for start; start captures frame, mode, clears counter
//   SEND  | presenting word cnt; advances on each out_valid && out_ready
//   DONE  | one-cycle done pulse after the final handshake
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - snapshot request, honoured only in IDLE
//   Small_or_Big  - column-set select, captured with start
//   frame_in      - 16 words, word k at [32k+31:32k]
//   out_data      - current word (0 when not streaming)
//   out_valid     - out_data valid
//   out_ready     - consumer ready
//   out_index     - frame index of current word
//   out_last      - current word is the final one of the burst
//   busy          - streaming in progress
//   done          - one-cycle pulse after the last handshake
module frame_stream_reader #(
  parameter int DATA_W = 32,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               Small_or_Big,
  input  logic [DATA_W*N_ROWS*N_COLS-1:0]    frame_in,
  output logic [DATA_W-1:0]                  out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [3:0]                         out_index,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  import frame_pkg::*;

  localparam int WORDS = N_ROWS * N_COLS;

  state_t            state, state_nxt;
  logic              mode;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] frame_buf [WORDS];
  logic [3:0]        k;
  logic              last;
  logic              take_start;
  logic              hs;

  assign take_start = (state == IDLE) && start;
  assign hs         = (state == SEND) && out_ready;

  frame_index_gen u_index_gen (
    .mode (mode),
    .cnt  (cnt),
    .k    (k),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (out_ready && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= MODE_SMALL;
      cnt  <= 4'd0;
      for (int i = 0; i < WORDS; i++) frame_buf[i] <= '0;
    end else if (take_start) begin
      mode <= Small_or_Big;
      cnt  <= 4'd0;
      for (int i = 0; i < WORDS; i++) frame_buf[i] <= frame_in[i*DATA_W +: DATA_W];
    end else if (hs) begin
      // clear on the final word so cnt never passes count-1
      cnt <= last ? 4'd0 : (cnt + 4'd1);
    end
  end

  // Stream outputs are forced to zero outside SEND so idle/done look like reset.
  always_comb begin
    out_valid = (state == SEND);
    out_data  = '0;
    out_index = 4'd0;
    out_last  = 1'b0;
    busy      = (state == SEND);
    done      = (state == DONE);
    if (state == SEND) begin
      out_data  = frame_buf[k];
      out_index = k;
      out_last  = last;
    end
  end

endmodule
